// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants: ALU codes, ALUOp encodings, ctrl bit indices
package pipe_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // {funct7, funct3} patterns recognised for R-type
  localparam logic [9:0] FUNCT_ADD = 10'b0000000_000;
  localparam logic [9:0] FUNCT_SUB = 10'b0100000_000;
  localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;
  localparam logic [9:0] FUNCT_AND = 10'b0000000_111;
  localparam logic [9:0] FUNCT_OR  = 10'b0000000_110;

  localparam int CTRL_W        = 4;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational ALUOp + funct to 3-bit ALU control decode
module alu_ctrl_dec
  import pipe_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [9:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_AND;
    case (aluop)
      ALUOP_LDST:  alu_ctrl = ALU_ADD;
      ALUOP_BR:    alu_ctrl = ALU_SUB;
      ALUOP_ITYPE: alu_ctrl = ALU_ADD;
      ALUOP_RTYPE: begin
        // unrecognised funct falls back to AND
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_MUL: alu_ctrl = ALU_MUL;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          default:   alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX register with ALU control, operand forwarding and load-use stall
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic [RADDR_W-1:0] id_rs1_i,
  input  logic [RADDR_W-1:0] id_rs2_i,
  input  logic [RADDR_W-1:0] id_rd_i,
  input  logic [XLEN-1:0]    id_rs1_data_i,
  input  logic [XLEN-1:0]    id_rs2_data_i,
  input  logic [XLEN-1:0]    id_imm_i,
  input  logic [1:0]         id_aluop_i,
  input  logic [9:0]         id_funct_i,
  input  logic               id_alusrc_i,
  input  logic [CTRL_W-1:0]  id_ctrl_i,
  input  logic [RADDR_W-1:0] exm_rd_i,
  input  logic               exm_we_i,
  input  logic [XLEN-1:0]    exm_data_i,
  input  logic [RADDR_W-1:0] mwb_rd_i,
  input  logic               mwb_we_i,
  input  logic [XLEN-1:0]    mwb_data_i,
  output logic               stall_o,
  output logic               valid_o,
  output logic [XLEN-1:0]    data1_o,
  output logic [XLEN-1:0]    data2_o,
  output logic [XLEN-1:0]    store_data_o,
  output logic [2:0]         ALUCtrl_o,
  output logic [RADDR_W-1:0] rd_o,
  output logic [CTRL_W-1:0]  ctrl_o
);

  logic               valid_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [RADDR_W-1:0] rd_q;
  logic [RADDR_W-1:0] rs1_q;
  logic [RADDR_W-1:0] rs2_q;
  logic [XLEN-1:0]    rs1_data_q;
  logic [XLEN-1:0]    rs2_data_q;
  logic [XLEN-1:0]    imm_q;
  logic               alusrc_q;
  logic [2:0]         alu_ctrl_q;
  logic [2:0]         alu_ctrl_d;
  logic               bubble;
  logic [XLEN-1:0]    fwd_rs1;
  logic [XLEN-1:0]    fwd_rs2;

  alu_ctrl_dec u_alu_ctrl_dec (
    .aluop    (id_aluop_i),
    .funct    (id_funct_i),
    .alu_ctrl (alu_ctrl_d)
  );

  // Load in EX whose destination ID is about to read: hold ID/IF one cycle
  assign stall_o = id_valid_i && valid_q && ctrl_q[CTRL_MEMREAD] && (rd_q != '0) &&
                   ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));

  assign bubble = stall_o || flush_i || !id_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      alu_ctrl_q <= ALU_AND;
    end else begin
      valid_q    <= !bubble;
      ctrl_q     <= bubble ? '0 : id_ctrl_i;
      rd_q       <= bubble ? '0 : id_rd_i;
      rs1_q      <= id_rs1_i;
      rs2_q      <= id_rs2_i;
      rs1_data_q <= id_rs1_data_i;
      rs2_data_q <= id_rs2_data_i;
      imm_q      <= id_imm_i;
      alusrc_q   <= id_alusrc_i;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  // Youngest producer wins; x0 is hard-wired and never forwarded
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exm_we_i && (exm_rd_i != '0) && (exm_rd_i == rs1_q)) begin
      fwd_rs1 = exm_data_i;
    end else if (mwb_we_i && (mwb_rd_i != '0) && (mwb_rd_i == rs1_q)) begin
      fwd_rs1 = mwb_data_i;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (exm_we_i && (exm_rd_i != '0) && (exm_rd_i == rs2_q)) begin
      fwd_rs2 = exm_data_i;
    end else if (mwb_we_i && (mwb_rd_i != '0) && (mwb_rd_i == rs2_q)) begin
      fwd_rs2 = mwb_data_i;
    end
  end

  assign data1_o      = fwd_rs1;
  assign data2_o      = alusrc_q ? imm_q : fwd_rs2;
  assign store_data_o = fwd_rs2;
  assign ALUCtrl_o    = alu_ctrl_q;
  assign valid_o      = valid_q;
  assign rd_o         = rd_q;
  assign ctrl_o       = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed table-driven bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [1:0]  id_aluop_i;
  logic [9:0]  id_funct_i;
  logic        id_alusrc_i;
  logic [3:0]  id_ctrl_i;
  logic [4:0]  exm_rd_i, mwb_rd_i;
  logic        exm_we_i, mwb_we_i;
  logic [31:0] exm_data_i, mwb_data_i;
  logic        stall_o, valid_o;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [2:0]  ALUCtrl_o;
  logic [4:0]  rd_o;
  logic [3:0]  ctrl_o;

  int n_assert = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_aluop_i(id_aluop_i), .id_funct_i(id_funct_i), .id_alusrc_i(id_alusrc_i),
    .id_ctrl_i(id_ctrl_i), .exm_rd_i(exm_rd_i), .exm_we_i(exm_we_i), .exm_data_i(exm_data_i),
    .mwb_rd_i(mwb_rd_i), .mwb_we_i(mwb_we_i), .mwb_data_i(mwb_data_i),
    .stall_o(stall_o), .valid_o(valid_o), .data1_o(data1_o), .data2_o(data2_o),
    .store_data_o(store_data_o), .ALUCtrl_o(ALUCtrl_o), .rd_o(rd_o), .ctrl_o(ctrl_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        id_valid;
    logic        flush;
    logic [1:0]  aluop;
    logic [9:0]  funct;
    logic        alusrc;
    logic [3:0]  ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_we, mwb_we;
    logic [31:0] exm_data, mwb_data;
    logic        chk_data;
    logic        e_valid;
    logic [3:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic [2:0]  e_alu;
    logic [31:0] e1, e2, est;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_fwd();
    exm_rd_i = 0; exm_we_i = 0; exm_data_i = 0;
    mwb_rd_i = 0; mwb_we_i = 0; mwb_data_i = 0;
  endtask

  task automatic drive_id(input logic v, input logic [1:0] aluop, input logic [9:0] funct,
                          input logic alusrc, input logic [3:0] ctrl,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    id_valid_i = v; id_aluop_i = aluop; id_funct_i = funct; id_alusrc_i = alusrc;
    id_ctrl_i = ctrl; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.id_valid = 1; v.flush = 0; v.aluop = 2'b10; v.funct = 10'b0; v.alusrc = 0;
    v.ctrl = 4'b1000; v.rs1 = 1; v.rs2 = 2; v.rd = 6; v.d1 = 0; v.d2 = 0; v.imm = 0;
    v.exm_rd = 0; v.mwb_rd = 0; v.exm_we = 0; v.mwb_we = 0; v.exm_data = 0; v.mwb_data = 0;
    v.chk_data = 1; v.e_valid = 1; v.e_ctrl = 4'b1000; v.e_rd = 6; v.e_alu = 3'b010;
    v.e1 = 0; v.e2 = 0; v.est = 0;
    return v;
  endfunction

  function automatic vec_t rt(input logic [9:0] funct, input logic [31:0] a,
                              input logic [31:0] b, input logic [2:0] alu);
    vec_t v = blank();
    v.funct = funct; v.d1 = a; v.d2 = b; v.e_alu = alu; v.e1 = a; v.e2 = b; v.est = b;
    return v;
  endfunction

  initial begin
    vec_t v;

    // Reset held two cycles while ID offers a valid load
    rst_i = 1; flush_i = 0; clear_fwd();
    drive_id(1, 2'b00, 10'h3ff, 1, 4'b1111, 9, 9, 9, 32'h55, 32'h66, 32'h77);
    tick(); tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_alu", ALUCtrl_o, 3'b000);
    chk("rst_stall", stall_o, 0);
    chk("rst_data1", data1_o, 0);
    rst_i = 0;

    v = rt(10'b0000000_000, 5, 7, 3'b010);         vecs.push_back(v);
    v = rt(10'b0100000_000, 20, 3, 3'b110);        vecs.push_back(v);
    v = rt(10'b0000001_000, 6, 7, 3'b100);         vecs.push_back(v);
    v = rt(10'b0000000_111, 32'hF0, 32'h3C, 3'b000); vecs.push_back(v);
    v = rt(10'b0000000_110, 32'h0F, 32'hF0, 3'b001); vecs.push_back(v);
    v = rt(10'b0000011_101, 32'h11, 32'h22, 3'b000); vecs.push_back(v);
    // EX/MEM beats MEM/WB on the same register
    v = rt(10'b0, 32'h33, 32'h22, 3'b010);
    v.rs1 = 3; v.exm_rd = 3; v.exm_we = 1; v.exm_data = 32'hAA;
    v.mwb_rd = 3; v.mwb_we = 1; v.mwb_data = 32'hBB; v.e1 = 32'hAA; vecs.push_back(v);
    v.exm_we = 0; v.e1 = 32'hBB; vecs.push_back(v);
    // x0 is never forwarded
    v = rt(10'b0, 32'h1234, 32'h22, 3'b010);
    v.rs1 = 0; v.exm_rd = 0; v.exm_we = 1; v.exm_data = 32'hAA;
    v.mwb_rd = 0; v.mwb_we = 1; v.mwb_data = 32'hBB; vecs.push_back(v);
    // independent sources per operand
    v = rt(10'b0, 1, 2, 3'b010);
    v.rs1 = 6; v.rs2 = 7; v.exm_rd = 6; v.exm_we = 1; v.exm_data = 32'h60;
    v.mwb_rd = 7; v.mwb_we = 1; v.mwb_data = 32'h70; v.e1 = 32'h60; v.e2 = 32'h70; v.est = 32'h70;
    vecs.push_back(v);
    v = rt(10'b0, 1, 2, 3'b010);
    v.rs1 = 6; v.rs2 = 7; v.exm_rd = 7; v.exm_we = 1; v.exm_data = 32'h77;
    v.mwb_rd = 7; v.mwb_we = 1; v.mwb_data = 32'h70; v.e1 = 1; v.e2 = 32'h77; v.est = 32'h77;
    vecs.push_back(v);
    // addi with negative immediate; store data still forwarded rs2
    v = blank();
    v.aluop = 2'b11; v.alusrc = 1; v.imm = 32'hFFFF_FFFC; v.d1 = 10; v.d2 = 5; v.rs2 = 8; v.rd = 9;
    v.exm_rd = 8; v.exm_we = 1; v.exm_data = 32'h88; v.e_rd = 9;
    v.e1 = 10; v.e2 = 32'hFFFF_FFFC; v.est = 32'h88; vecs.push_back(v);
    // flushed sd becomes a bubble
    v = blank();
    v.aluop = 2'b00; v.ctrl = 4'b0001; v.rd = 12; v.flush = 1; v.alusrc = 1;
    v.chk_data = 0; v.e_valid = 0; v.e_ctrl = 0; v.e_rd = 0; vecs.push_back(v);
    // branch compare
    v = blank();
    v.aluop = 2'b01; v.ctrl = 4'b0000; v.rd = 0; v.d1 = 4; v.d2 = 4;
    v.e_ctrl = 0; v.e_rd = 0; v.e_alu = 3'b110; v.e1 = 4; v.e2 = 4; v.est = 4; vecs.push_back(v);
    // ID empty
    v = blank();
    v.id_valid = 0; v.rd = 3; v.chk_data = 0; v.e_valid = 0; v.e_ctrl = 0; v.e_rd = 0;
    vecs.push_back(v);
    // plain load, address = base + imm
    v = blank();
    v.aluop = 2'b00; v.alusrc = 1; v.imm = 8; v.ctrl = 4'b0110; v.rd = 10; v.d1 = 32'h100;
    v.e_ctrl = 4'b0110; v.e_rd = 10; v.e1 = 32'h100; v.e2 = 8; vecs.push_back(v);

    foreach (vecs[i]) begin
      v = vecs[i];
      clear_fwd();
      flush_i = v.flush;
      drive_id(v.id_valid, v.aluop, v.funct, v.alusrc, v.ctrl, v.rs1, v.rs2, v.rd,
               v.d1, v.d2, v.imm);
      tick();
      flush_i = 0;
      exm_rd_i = v.exm_rd; exm_we_i = v.exm_we; exm_data_i = v.exm_data;
      mwb_rd_i = v.mwb_rd; mwb_we_i = v.mwb_we; mwb_data_i = v.mwb_data;
      #1;
      chk($sformatf("v%0d_valid", i), valid_o, v.e_valid);
      chk($sformatf("v%0d_ctrl", i), ctrl_o, v.e_ctrl);
      chk($sformatf("v%0d_rd", i), rd_o, v.e_rd);
      chk($sformatf("v%0d_stall", i), stall_o, 0);
      if (v.chk_data) begin
        chk($sformatf("v%0d_alu", i), ALUCtrl_o, v.e_alu);
        chk($sformatf("v%0d_data1", i), data1_o, v.e1);
        chk($sformatf("v%0d_data2", i), data2_o, v.e2);
        chk($sformatf("v%0d_store", i), store_data_o, v.est);
      end
    end

    // Load-use: lw x4 then add using x4 as rs2
    clear_fwd();
    drive_id(1, 2'b00, 10'b0, 1, 4'b1110, 1, 0, 4, 32'h200, 0, 4);
    tick();
    drive_id(1, 2'b10, 10'b0, 0, 4'b1000, 1, 4, 5, 3, 9, 0);
    #1;
    chk("lu_stall", stall_o, 1);
    chk("lu_ex_valid", valid_o, 1);
    tick();
    chk("lu_bubble_valid", valid_o, 0);
    chk("lu_bubble_ctrl", ctrl_o, 0);
    chk("lu_bubble_stall", stall_o, 0);
    tick();
    chk("lu_resume_valid", valid_o, 1);
    chk("lu_resume_stall", stall_o, 0);
    chk("lu_resume_rd", rd_o, 5);
    chk("lu_resume_ctrl", ctrl_o, 4'b1000);

    // Stall together with flush: bubble, stall stays combinational
    drive_id(1, 2'b00, 10'b0, 1, 4'b1110, 1, 0, 4, 32'h200, 0, 4);
    tick();
    drive_id(1, 2'b10, 10'b0, 0, 4'b1000, 4, 2, 5, 3, 9, 0);
    flush_i = 1;
    #1;
    chk("sf_stall", stall_o, 1);
    tick();
    flush_i = 0;
    chk("sf_valid", valid_o, 0);
    chk("sf_ctrl", ctrl_o, 0);

    // Mid-operation reset clears the slot
    drive_id(1, 2'b10, 10'b0100000_000, 0, 4'b1000, 1, 2, 7, 32'h99, 1, 0);
    tick();
    chk("mr_pre_valid", valid_o, 1);
    chk("mr_pre_alu", ALUCtrl_o, 3'b110);
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("mr_valid", valid_o, 0);
    chk("mr_ctrl", ctrl_o, 0);
    chk("mr_rd", rd_o, 0);
    chk("mr_alu", ALUCtrl_o, 3'b000);
    chk("mr_data1", data1_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
